// File: rtl/addsub_result_display.sv
// addsub_result_display
//   Takes the sign/magnitude result of the 4-bit adder/subtractor. It captures
//   the result on a load strobe and converts the 5-bit magnitude to two BCD
//   digits with a serial shift-add-3 engine. It drives a 3-digit multiplexed
//   7-segment display showing sign, tens and ones.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for load; display shows the last latched result
//   CONV  | one double-dabble step per clock, five steps in total
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sign      in   result sign, 1 = negative
//   S         in   result magnitude 0..31
//   load      in   single-cycle strobe: capture sign/S and start conversion
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when new digits are latched
//   bcd_tens  out  latched tens digit (0..3)
//   bcd_ones  out  latched ones digit (0..9)
//   neg       out  latched display sign (negative zero suppressed)
//   an        out  digit enables, active-low one-hot {sign, tens, ones}
//   seg       out  segments, active-low, gfedcba
module addsub_result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sign,
    input  logic [4:0] S,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       neg,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t     r_state;
    logic [4:0] r_bin;
    logic [7:0] r_bcd;
    logic [2:0] r_step;
    logic       r_sign_q;
    logic       r_nz;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_bcd_tens;
    logic [3:0] r_bcd_ones;
    logic       r_neg;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_digit;
    logic [2:0]       r_an;
    logic [6:0]       r_seg;

    logic [3:0] w_adj_ones;
    logic [3:0] w_adj_tens;
    logic [7:0] w_bcd_next;
    logic [4:0] w_bin_next;

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // One double-dabble step: correct each nibble, then shift {bcd, bin} left.
    always_comb begin
        w_adj_ones = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_adj_tens = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_bcd_next = {w_adj_tens[2:0], w_adj_ones, r_bin[4]};
        w_bin_next = {r_bin[3:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            r_sign_q   <= 1'b0;
            r_nz       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd_tens <= '0;
            r_bcd_ones <= '0;
            r_neg      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_bin    <= S;
                        r_sign_q <= sign;
                        // The binary register is shifted away during the
                        // conversion, so remember whether the value was zero.
                        r_nz     <= (S != 5'd0);
                        r_bcd    <= '0;
                        r_step   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd  <= w_bcd_next;
                    r_bin  <= w_bin_next;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd4) begin
                        r_bcd_tens <= w_bcd_next[7:4];
                        r_bcd_ones <= w_bcd_next[3:0];
                        r_neg      <= r_sign_q & r_nz;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
            r_an       <= 3'b110;
            r_seg      <= 7'b1000000;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_digit    <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            case (r_digit)
                2'd0: begin
                    r_an  <= 3'b110;
                    r_seg <= f_glyph(r_bcd_ones);
                end
                2'd1: begin
                    r_an  <= 3'b101;
                    r_seg <= (r_bcd_tens == 4'd0) ? SEG_BLANK : f_glyph(r_bcd_tens);
                end
                default: begin
                    r_an  <= 3'b011;
                    r_seg <= r_neg ? SEG_DASH : SEG_BLANK;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd_tens = r_bcd_tens;
    assign bcd_ones = r_bcd_ones;
    assign neg      = r_neg;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule
